// File: rtl/udp_writer.sv
// udp_writer: snapshots a CAPACITY-byte word and streams it MSB-first to udp_packet as one UDP payload.
// Optional UDP_WRITER_SEQ_EN prepends a 16-bit packet sequence number to the payload.
module udp_writer #(
  parameter int CAPACITY = 1,
  parameter int MIN_GAP = 1024,
  parameter int WAIT_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send,
  input  logic [CAPACITY*8-1:0] i_data,
  output logic                  trig,
  input  logic                  read_en,
  output logic [7:0]            o_data,
  output logic [15:0]           data_len,
  output logic                  busy,
  output logic                  dropped,
  output logic                  cap_err
);
`ifdef UDP_WRITER_SEQ_EN
  localparam int LEN = CAPACITY + 2;
`else
  localparam int LEN = CAPACITY;
`endif
  localparam int FW = LEN * 8;
  localparam int IW = $clog2(LEN + 1);
  localparam int CMAX = WAIT_TIMEOUT > MIN_GAP ? WAIT_TIMEOUT : MIN_GAP;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, ARM, WAIT, SEND, GAP} state_t;
  state_t state, state_nx;
  logic [CAPACITY*8-1:0] snap;
  logic [IW-1:0] idx, idx_nx;
  logic [CW-1:0] cnt;
  logic [FW-1:0] frame, frame_nx, frame_sh;
  logic short_pkt, rd;
`ifdef UDP_WRITER_SEQ_EN
  logic [15:0] seq;
  assign frame = {seq, snap};
  assign frame_nx = {seq, i_data};
  always_ff @(posedge clk or posedge rst)
    if (rst) seq <= '0;
    else if (state == SEND && !read_en && !short_pkt) seq <= seq + 1'b1;
`else
  assign frame = snap;
  assign frame_nx = i_data;
`endif
  assign short_pkt = idx < IW'(LEN);
  assign idx_nx = short_pkt ? idx + 1'b1 : idx;
  // Shifting past the frame end yields zero, which doubles as min-frame padding.
  assign frame_sh = frame << (8 * int'(idx_nx));
  assign rd = read_en && (state == WAIT || state == SEND);
  assign busy = state != IDLE;
  assign dropped = send && busy;
  assign data_len = 16'(LEN);
  always_comb begin
    state_nx = state;
    trig = 1'b0;
    cap_err = 1'b0;
    case (state)
      IDLE: state_nx = send ? ARM : IDLE;
      ARM: begin
        trig = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        cap_err = !read_en && cnt == CW'(WAIT_TIMEOUT - 1);
        state_nx = read_en ? SEND : cap_err ? GAP : WAIT;
      end
      SEND: begin
        cap_err = !read_en && short_pkt;
        state_nx = read_en ? SEND : GAP;
      end
      GAP: state_nx = cnt == CW'(MIN_GAP - 1) ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      snap <= '0;
      idx <= '0;
      cnt <= '0;
      o_data <= '0;
    end else begin
      state <= state_nx;
      cnt <= state_nx != state ? '0 : (state == WAIT || state == GAP) ? cnt + 1'b1 : cnt;
      if (state == IDLE && send) begin
        snap <= i_data;
        idx <= '0;
        o_data <= frame_nx[FW-1 -: 8];
      end
      if (rd) begin
        idx <= idx_nx;
        o_data <= frame_sh[FW-1 -: 8];
      end
    end
endmodule

// File: tb/tb_udp_writer.sv
// tb_udp_writer: directed tests for udp_writer (CAPACITY=4, MIN_GAP=8, WAIT_TIMEOUT=100).
// Works with or without UDP_WRITER_SEQ_EN defined.
module tb_udp_writer;
`ifdef UDP_WRITER_SEQ_EN
  localparam int LEN = 6;
`else
  localparam int LEN = 4;
`endif
  localparam int MIN_GAP = 8;
  logic clk = 0, rst = 1, send = 0, read_en = 0;
  logic [31:0] i_data = '0;
  logic trig, busy, dropped, cap_err;
  logic [7:0] o_data;
  logic [15:0] data_len;
  int n_chk = 0, n_fail = 0, trig_cnt = 0;
  logic [15:0] seq_m = '0;
  logic [31:0] pay = '0;

  udp_writer #(.CAPACITY(4), .MIN_GAP(MIN_GAP), .WAIT_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .send(send), .i_data(i_data), .trig(trig), .read_en(read_en),
    .o_data(o_data), .data_len(data_len), .busy(busy), .dropped(dropped), .cap_err(cap_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (trig) trig_cnt++;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] exp_byte(input int k);
`ifdef UDP_WRITER_SEQ_EN
    logic [47:0] f;
    f = {seq_m, pay} << (8 * k);
    return k < 6 ? f[47:40] : 8'h00;
`else
    logic [31:0] f;
    f = pay << (8 * k);
    return k < 4 ? f[31:24] : 8'h00;
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic obs;
    #3;
  endtask

  task automatic wait_gap(input string tag);
    int g = 0;
    for (int i = 0; i < 50; i++) begin
      step;
      obs;
      if (!busy) break;
      g++;
    end
    n_chk++;
    if (g !== MIN_GAP) begin n_fail++; $display("FAIL %s_gap: got %0d cycles want %0d", tag, g, MIN_GAP); end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #4;
    n_chk++;
    if ({trig, busy, dropped, cap_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {trig, busy, dropped, cap_err}); end
    n_chk++;
    if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", o_data); end
    n_chk++;
    if (data_len !== 16'(LEN)) begin n_fail++; $display("FAIL data_len: got %0d want %0d", data_len, LEN); end
    step;
    rst = 0;
  endtask

  task automatic run_packet(input string tag, input int nrd, input logic [31:0] d);
    logic err;
    int t0;
    err = nrd < LEN;
    step;
    send = 1;
    i_data = d;
    pay = d;
    obs;
    n_chk++;
    if ({busy, dropped} !== 2'b00) begin n_fail++; $display("FAIL %s_idle: got %b want 00", tag, {busy, dropped}); end
    t0 = trig_cnt;
    step;
    send = 0;
    obs;
    n_chk++;
    if (trig !== 1'b1 || o_data !== exp_byte(0)) begin n_fail++; $display("FAIL %s_arm: trig %b data %h want 1 %h", tag, trig, o_data, exp_byte(0)); end
    for (int k = 0; k < nrd; k++) begin
      step;
      read_en = 1;
      obs;
      n_chk++;
      if (o_data !== exp_byte(k) || cap_err !== 1'b0) begin n_fail++; $display("FAIL %s_byte%0d: got %h err %b want %h err 0", tag, k, o_data, cap_err, exp_byte(k)); end
    end
    step;
    read_en = 0;
    obs;
    n_chk++;
    if (cap_err !== err) begin n_fail++; $display("FAIL %s_caperr: got %b want %b", tag, cap_err, err); end
    wait_gap(tag);
    n_chk++;
    if (trig_cnt - t0 !== 1) begin n_fail++; $display("FAIL %s_trigs: got %0d want 1", tag, trig_cnt - t0); end
    if (!err) seq_m++;
  endtask

  task automatic test_timeout;
    int w = 0;
    step;
    send = 1;
    i_data = 32'h0BADF00D;
    step;
    send = 0;
    obs;
    for (int i = 0; i < 200; i++) begin
      step;
      obs;
      w++;
      if (cap_err) break;
    end
    n_chk++;
    if (w !== 100) begin n_fail++; $display("FAIL timeout_at: got %0d cycles want 100", w); end
    wait_gap("timeout");
  endtask

  task automatic test_dropped;
    int t0;
    step;
    send = 1;
    i_data = 32'hDEADBEEF;
    pay = 32'hDEADBEEF;
    t0 = trig_cnt;
    step;
    obs;
    n_chk++;
    if (dropped !== 1'b1 || trig !== 1'b1) begin n_fail++; $display("FAIL drop_arm: dropped %b trig %b want 1 1", dropped, trig); end
    step;
    i_data = 32'h12345678;
    obs;
    n_chk++;
    if (dropped !== 1'b1) begin n_fail++; $display("FAIL drop_wait: got %b want 1", dropped); end
    for (int k = 0; k < LEN; k++) begin
      step;
      read_en = 1;
      obs;
      n_chk++;
      if (dropped !== 1'b1 || o_data !== exp_byte(k)) begin n_fail++; $display("FAIL drop_byte%0d: dropped %b data %h want 1 %h", k, dropped, o_data, exp_byte(k)); end
    end
    step;
    read_en = 0;
    obs;
    n_chk++;
    if (cap_err !== 1'b0 || dropped !== 1'b1) begin n_fail++; $display("FAIL drop_end: err %b dropped %b want 0 1", cap_err, dropped); end
    for (int k = 0; k < 3; k++) begin
      step;
      obs;
      n_chk++;
      if (dropped !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL drop_gap%0d: dropped %b busy %b want 1 1", k, dropped, busy); end
    end
    step;
    send = 0;
    for (int i = 0; i < 50 && busy; i++) step;
    obs;
    n_chk++;
    if (trig_cnt - t0 !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_trigs: trigs %0d busy %b want 1 0", trig_cnt - t0, busy); end
    seq_m++;
  endtask

  task automatic test_reset_mid;
    step;
    send = 1;
    i_data = 32'hCAFEF00D;
    step;
    send = 0;
    step;
    read_en = 1;
    step;
    step;
    rst = 1;
    obs;
    n_chk++;
    if ({trig, busy, dropped, cap_err} !== 4'b0 || o_data !== 8'h00) begin n_fail++; $display("FAIL midrst: flags %b data %h want 0000 00", {trig, busy, dropped, cap_err}, o_data); end
    seq_m = '0;
    step;
    rst = 0;
    read_en = 0;
    step;
    run_packet("after_rst", LEN, 32'hCAFEF00D);
  endtask

  initial begin
    test_reset;
    run_packet("basic", LEN, 32'hDEADBEEF);
    run_packet("pad", LEN + 2, 32'hDEADBEEF);
    run_packet("short", 2, 32'hA1B2C3D4);
    test_timeout;
    run_packet("post_to", LEN, 32'h01020304);
    test_dropped;
    run_packet("seq", LEN, 32'hFFEE0011);
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
